// File: rtl/sparse_mac_pkg.sv
// ---------------------------------------------------------------------------
// sparse_mac_pkg
// Shared definitions for the sparse CNN signed accumulator slice.
//   PROD_W     : width of the unsigned product magnitude from the LUT multiplier
//   ACC_W_DEF  : default accumulator / output width (signed)
//   CNT_W_DEF  : default width of the non-zero term counter
//   state_t    : accumulator control states
// Optional feature macro used by this slice: SPARSE_MAC_ACC_SAT_EN
// ---------------------------------------------------------------------------
package sparse_mac_pkg;

  localparam int PROD_W    = 6;
  localparam int ACC_W_DEF = 16;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/sparse_mac_acc_if.sv
// ---------------------------------------------------------------------------
// sparse_mac_acc_if
// Product-beat input stream and window-result output stream of the sparse
// accumulator, both valid/ready.
//   in_valid/in_ready          : beat handshake
//   in_prod                    : unsigned product magnitude (0..49)
//   in_neg                     : product is negative
//   in_zero                    : sparse skip, term ignored
//   in_last                    : final term of the kernel window
//   out_valid/out_ready        : result handshake
//   out_data                   : signed window sum
//   out_nz_cnt                 : non-zero term count of the window
//   out_ovf                    : sticky saturation flag of the window
// Modports: master = upstream/downstream side, slave = accumulator.
// ---------------------------------------------------------------------------
interface sparse_mac_acc_if
  import sparse_mac_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
);

  logic                    in_valid;
  logic                    in_ready;
  logic [PROD_W-1:0]       in_prod;
  logic                    in_neg;
  logic                    in_zero;
  logic                    in_last;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [ACC_W-1:0] out_data;
  logic [CNT_W-1:0]        out_nz_cnt;
  logic                    out_ovf;

  modport master (
    output in_valid, in_prod, in_neg, in_zero, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_nz_cnt, out_ovf
  );

  modport slave (
    input  in_valid, in_prod, in_neg, in_zero, in_last, out_ready,
    output in_ready, out_valid, out_data, out_nz_cnt, out_ovf
  );

endinterface

// File: rtl/sparse_mac_sat_add.sv
// ---------------------------------------------------------------------------
// sparse_mac_sat_add
// Combinational signed add of the running accumulator and one signed term.
//   a, b : signed ACC_W-bit operands
//   sum  : result (saturated or wrapped)
//   ovf  : high when the add was clamped
// With SPARSE_MAC_ACC_SAT_EN defined the sum clamps to the signed range and
// ovf flags the clamp; otherwise the sum wraps and ovf is constant 0.
// ---------------------------------------------------------------------------
module sparse_mac_sat_add #(
  parameter int ACC_W = 16
) (
  input  logic signed [ACC_W-1:0] a,
  input  logic signed [ACC_W-1:0] b,
  output logic signed [ACC_W-1:0] sum,
  output logic                    ovf
);

`ifdef SPARSE_MAC_ACC_SAT_EN
  logic signed [ACC_W:0] full;

  // One guard bit: overflow shows up as the two top bits disagreeing, and
  // the guard bit then tells which rail to clamp to.
  always_comb begin
    full = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    ovf  = (full[ACC_W] != full[ACC_W-1]);
    sum  = full[ACC_W-1:0];
    if (ovf) begin
      sum = full[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                        : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end
`else
  assign sum = a + b;
  assign ovf = 1'b0;
`endif

endmodule

// File: rtl/sparse_mac_acc.sv
// ---------------------------------------------------------------------------
// sparse_mac_acc
// Signed window accumulator behind the 3x3 magnitude LUT multiplier. Applies
// the sign to each product, skips sparse terms, sums one kernel window
// (terminated by in_last) and presents the sum plus the non-zero term count.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : sparse_mac_acc_if.slave (input beats and window results)
// Optional feature macro: SPARSE_MAC_ACC_SAT_EN (saturating adds + out_ovf).
// ---------------------------------------------------------------------------
module sparse_mac_acc
  import sparse_mac_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input logic           clk,
  input logic           rst,
  sparse_mac_acc_if.slave bus
);

  state_t                  state;
  logic signed [ACC_W-1:0] acc;
  logic [CNT_W-1:0]        cnt;
  logic                    ovf_acc;

  logic                    out_valid_q;
  logic signed [ACC_W-1:0] out_data_q;
  logic [CNT_W-1:0]        out_cnt_q;
  logic                    out_ovf_q;

  logic                    in_ready;
  logic                    in_fire;
  logic                    out_fire;
  logic                    term_nz;
  logic signed [ACC_W-1:0] term;
  logic signed [ACC_W-1:0] sum;
  logic                    add_ovf;
  logic [CNT_W-1:0]        cnt_next;
  logic                    ovf_next;

  assign in_ready = !out_valid_q || bus.out_ready;
  assign in_fire  = bus.in_valid && in_ready;
  assign out_fire = out_valid_q && bus.out_ready;

  // A zero product counts as sparse even when flagged negative, so there is
  // never a negative zero and it never bumps the non-zero counter.
  assign term_nz = !bus.in_zero && (bus.in_prod != '0);

  always_comb begin
    term = '0;
    if (term_nz) begin
      term = {{(ACC_W-PROD_W){1'b0}}, bus.in_prod};
      if (bus.in_neg) begin
        term = -term;
      end
    end
  end

  sparse_mac_sat_add #(.ACC_W(ACC_W)) u_add (
    .a   (acc),
    .b   (term),
    .sum (sum),
    .ovf (add_ovf)
  );

  assign cnt_next = (term_nz && (cnt != '1)) ? cnt + CNT_W'(1) : cnt;
  assign ovf_next = ovf_acc | add_ovf;

  // Window control. A last beat always wins over a same-cycle transfer so
  // back-to-back single-beat windows keep out_valid high continuously.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      acc         <= '0;
      cnt         <= '0;
      ovf_acc     <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_cnt_q   <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      if (in_fire) begin
        if (bus.in_last) begin
          out_data_q <= sum;
          out_cnt_q  <= cnt_next;
          out_ovf_q  <= ovf_next;
          acc        <= '0;
          cnt        <= '0;
          ovf_acc    <= 1'b0;
        end else begin
          acc        <= sum;
          cnt        <= cnt_next;
          ovf_acc    <= ovf_next;
        end
      end

      case (state)
        IDLE, ACCUM: begin
          if (in_fire) begin
            state       <= bus.in_last ? HOLD : ACCUM;
            out_valid_q <= bus.in_last;
          end
        end
        HOLD: begin
          if (in_fire && bus.in_last) begin
            state       <= HOLD;
            out_valid_q <= 1'b1;
          end else if (out_fire) begin
            state       <= in_fire ? ACCUM : IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_nz_cnt = out_cnt_q;
  assign bus.out_ovf    = out_ovf_q;

endmodule

// File: tb/tb_sparse_mac_acc.sv
// ---------------------------------------------------------------------------
// tb_sparse_mac_acc
// Drives the same beat stream into a 16-bit and an 8-bit accumulator and
// compares both against a window-level reference model: the terms of each
// window are kept in a queue and folded with plain integer arithmetic
// (clamped per add when SPARSE_MAC_ACC_SAT_EN is defined, wrapped otherwise).
// ---------------------------------------------------------------------------
module tb_sparse_mac_acc;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_neg, in_zero, in_last, out_ready;
  logic [5:0] in_prod;

  int checks = 0;
  int errors = 0;

  // Window-level reference model state
  int  win_terms[$];
  int  exp_valid;
  int  exp_data16, exp_data8, exp_cnt, exp_ovf16, exp_ovf8;
  bit  just_reset;

  always #5 clk = ~clk;

  sparse_mac_acc_if #(.ACC_W(16), .CNT_W(8)) bus16 ();
  sparse_mac_acc_if #(.ACC_W(8),  .CNT_W(8)) bus8 ();

  assign bus16.in_valid  = in_valid;
  assign bus16.in_prod   = in_prod;
  assign bus16.in_neg    = in_neg;
  assign bus16.in_zero   = in_zero;
  assign bus16.in_last   = in_last;
  assign bus16.out_ready = out_ready;
  assign bus8.in_valid   = in_valid;
  assign bus8.in_prod    = in_prod;
  assign bus8.in_neg     = in_neg;
  assign bus8.in_zero    = in_zero;
  assign bus8.in_last    = in_last;
  assign bus8.out_ready  = out_ready;

  sparse_mac_acc #(.ACC_W(16), .CNT_W(8)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (bus16.slave)
  );

  sparse_mac_acc #(.ACC_W(8), .CNT_W(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8.slave)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Sum a window's terms at width w, clamping each add or wrapping.
  function automatic int fold(input int t[$], input int w, output int ovf);
    int s  = 0;
    int lo = -(1 << (w - 1));
    int hi = (1 << (w - 1)) - 1;
    ovf = 0;
    foreach (t[i]) begin
      s = s + t[i];
`ifdef SPARSE_MAC_ACC_SAT_EN
      if (s > hi) begin
        s = hi;
        ovf = 1;
      end else if (s < lo) begin
        s = lo;
        ovf = 1;
      end
`else
      s = s & ((1 << w) - 1);
      if (s > hi) s = s - (1 << w);
`endif
    end
    return s;
  endfunction

  // Compare the visible outputs of both DUTs against the model.
  task automatic checkAll();
    int d16, d8;
    d16 = bus16.out_data;
    d8  = bus8.out_data;
    checkOutput("valid16", int'(bus16.out_valid), exp_valid);
    checkOutput("valid8",  int'(bus8.out_valid),  exp_valid);
    if (exp_valid != 0 || just_reset) begin
      checkOutput("data16", d16, exp_data16);
      checkOutput("data8",  d8,  exp_data8);
      checkOutput("cnt16",  int'(bus16.out_nz_cnt), exp_cnt);
      checkOutput("cnt8",   int'(bus8.out_nz_cnt),  exp_cnt);
      checkOutput("ovf16",  int'(bus16.out_ovf),    exp_ovf16);
      checkOutput("ovf8",   int'(bus8.out_ovf),     exp_ovf8);
    end
    just_reset = 1'b0;
  endtask

  // One clock cycle: check outputs, drive a beat, advance the model.
  // Entered and left at a falling edge.
  task automatic applyStimulus(input bit v, input int prod, input bit neg, input bit zero,
                               input bit last, input bit oready, input bit r);
    int  term, nz, ready, o16, o8;
    checkAll();
    rst       = r;
    in_valid  = v;
    in_prod   = 6'(prod);
    in_neg    = neg;
    in_zero   = zero;
    in_last   = last;
    out_ready = oready;
    #1;
    ready = (exp_valid == 0 || oready) ? 1 : 0;
    if (!r) begin
      checkOutput("in_ready16", int'(bus16.in_ready), ready);
      checkOutput("in_ready8",  int'(bus8.in_ready),  ready);
    end
    if (r) begin
      win_terms.delete();
      exp_valid = 0; exp_data16 = 0; exp_data8 = 0;
      exp_cnt = 0; exp_ovf16 = 0; exp_ovf8 = 0;
      just_reset = 1'b1;
    end else if (v && ready != 0) begin
      term = (zero || prod == 0) ? 0 : (neg ? -prod : prod);
      win_terms.push_back(term);
      if (last) begin
        nz = 0;
        foreach (win_terms[i]) if (win_terms[i] != 0) nz++;
        exp_data16 = fold(win_terms, 16, o16);
        exp_data8  = fold(win_terms, 8, o8);
        exp_ovf16  = o16;
        exp_ovf8   = o8;
        exp_cnt    = (nz > 255) ? 255 : nz;
        exp_valid  = 1;
        win_terms.delete();
      end else if (exp_valid != 0 && oready) begin
        exp_valid = 0;
      end
    end else if (exp_valid != 0 && oready) begin
      exp_valid = 0;
    end
    @(negedge clk);
  endtask

  initial begin
    int d;
    rst = 1'b1; in_valid = 1'b0; in_prod = '0; in_neg = 1'b0;
    in_zero = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    exp_valid = 0; exp_data16 = 0; exp_data8 = 0;
    exp_cnt = 0; exp_ovf16 = 0; exp_ovf8 = 0; just_reset = 1'b1;
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 0, 1, 1);

    // Nine beats of +49 -> 441, nine non-zero terms
    for (int i = 0; i < 9; i++) applyStimulus(1, 49, 0, 0, i == 8, 1, 0);
    d = bus16.out_data;
    checkOutput("p441_valid", int'(bus16.out_valid), 1);
    checkOutput("p441_data", d, 441);
    checkOutput("p441_cnt", int'(bus16.out_nz_cnt), 9);

    // Mixed signs, a sparse beat and a negative zero -> -1, three terms
    applyStimulus(1, 35, 0, 0, 0, 1, 0);
    applyStimulus(1, 42, 1, 0, 0, 1, 0);
    applyStimulus(1, 12, 0, 1, 0, 1, 0);
    applyStimulus(1, 0,  1, 0, 0, 1, 0);
    applyStimulus(1, 6,  0, 0, 1, 1, 0);
    d = bus16.out_data;
    checkOutput("pmix_data", d, -1);
    checkOutput("pmix_cnt", int'(bus16.out_nz_cnt), 3);

    // Result held with out_ready low; upstream beats stall
    applyStimulus(1, 10, 0, 0, 1, 1, 0);
    for (int i = 0; i < 5; i++) applyStimulus(1, 33, 1, 0, 0, 0, 0);
    d = bus16.out_data;
    checkOutput("hold_data", d, 10);
    checkOutput("hold_ready", int'(bus16.in_ready), 0);
    applyStimulus(1, 3, 0, 0, 0, 1, 0);
    applyStimulus(1, 4, 0, 0, 1, 1, 0);
    d = bus16.out_data;
    checkOutput("after_hold", d, 7);

    // Back-to-back single-beat windows
    applyStimulus(1, 7, 0, 0, 1, 1, 0);
    d = bus16.out_data;
    checkOutput("b2b_7", d, 7);
    applyStimulus(1, 3, 1, 0, 1, 1, 0);
    d = bus16.out_data;
    checkOutput("b2b_m3", d, -3);
    checkOutput("b2b_valid", int'(bus16.out_valid), 1);
    applyStimulus(1, 0, 0, 0, 1, 1, 0);
    d = bus16.out_data;
    checkOutput("b2b_0", d, 0);
    checkOutput("b2b_cnt0", int'(bus16.out_nz_cnt), 0);

    // Overflow of the 8-bit instance
    for (int i = 0; i < 4; i++) applyStimulus(1, 49, 0, 0, i == 3, 1, 0);
    d = bus8.out_data;
`ifdef SPARSE_MAC_ACC_SAT_EN
    checkOutput("ovf8_data", d, 127);
    checkOutput("ovf8_flag", int'(bus8.out_ovf), 1);
`else
    checkOutput("ovf8_data", d, -60);
    checkOutput("ovf8_flag", int'(bus8.out_ovf), 0);
`endif
    d = bus16.out_data;
    checkOutput("ovf16_data", d, 196);
    applyStimulus(1, 5, 0, 0, 1, 1, 0);
    d = bus8.out_data;
    checkOutput("post_ovf_data", d, 5);
    checkOutput("post_ovf_flag", int'(bus8.out_ovf), 0);

    // Reset in the middle of a window discards it
    applyStimulus(0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1, 20, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 1);
    checkOutput("rst_valid", int'(bus16.out_valid), 0);
    applyStimulus(1, 7, 0, 0, 1, 1, 0);
    d = bus16.out_data;
    checkOutput("rst_data", d, 7);
    checkOutput("rst_cnt", int'(bus16.out_nz_cnt), 1);

    // Counter saturation: 301 alternating +1/-1 terms
    for (int i = 0; i < 301; i++) applyStimulus(1, 1, i % 2 == 1, 0, i == 300, 1, 0);
    checkOutput("cnt_sat", int'(bus16.out_nz_cnt), 255);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 9) < 7, $urandom_range(0, 49),
                    $urandom_range(0, 1) == 1, $urandom_range(0, 4) == 0,
                    $urandom_range(0, 3) == 0, $urandom_range(0, 9) < 7,
                    $urandom_range(0, 199) == 0);
    end
    applyStimulus(0, 0, 0, 0, 0, 1, 0);
    checkAll();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sparse_mac_acc.md
Name: sparse_mac_acc

Overview:
- Signed accumulator that sits directly downstream of the 3x3 magnitude LUT multiplier in the 4-bit sparse CNN datapath.
- Consumes a stream of unsigned 6-bit product magnitudes, each with a sign flag and a sparsity (zero-skip) flag.
- Applies the sign, accumulates one kernel window (group terminated by in_last) and emits one signed sum per group.
- Also emits a count of the non-zero terms in the group; input and output use valid/ready handshakes.

Parameters:
- ACC_W, 16, accumulator/output width in bits, signed; must be >= 7.
- CNT_W, 8, width of the non-zero term counter; the counter saturates at 2^CNT_W-1.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  product beat valid
- in_ready  out  1  accumulator can accept a beat
- in_prod  in  6  unsigned product magnitude, range 0..49
- in_neg  in  1  product is negative (sign(A) XOR sign(B))
- in_zero  in  1  sparse skip: operand zero, term ignored
- in_last  in  1  final term of the current window
- out_valid  out  1  group result valid
- out_ready  in  1  downstream accepts the result
- out_data  out  ACC_W  signed window sum
- out_nz_cnt  out  CNT_W  number of non-zero terms in the window
- out_ovf  out  1  sticky overflow seen in the window (0 when the feature is compiled out)

Behaviour:
- Reset: synchronous, active-high, one clock; reset is sampled every edge.
  - out_valid=0, out_data=0, out_nz_cnt=0, out_ovf=0; accumulator, counter and ovf cleared; state=IDLE.
  - Reset mid-window discards all partial state; no output is produced.
- States:
  - IDLE: no partial window.
  - ACCUM: at least one beat of a window accepted, in_last not yet seen.
  - HOLD: result presented on the output.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - A beat is accepted when in_valid && in_ready; an output transfer occurs when out_valid && out_ready.
- Term value:
  - term = 0 when in_zero=1 or in_prod=0.
  - Otherwise term = in_neg ? -in_prod : +in_prod, sign-extended to ACC_W.
  - A negative sign on a zero product yields 0 (no negative zero).
- Non-zero counter: increments only on accepted beats with term != 0; saturates at all-ones.
- Accepted beat, in_last=0: acc <= acc + term; IDLE->ACCUM.
- Accepted beat, in_last=1:
  - out_data <= acc + term; out_nz_cnt, out_ovf take their final values.
  - out_valid <= 1 on the next edge (latency 1 cycle from the last beat); acc, counter and ovf are cleared for the next window; state->HOLD.
  - A single-beat window (first beat has in_last=1) is legal.
- HOLD:
  - out_data, out_nz_cnt and out_ovf are held stable while out_ready=0; in_ready=0 stalls upstream.
  - On a transfer with no accepted last beat in the same cycle: out_valid <= 0; state becomes ACCUM if a non-last beat was accepted that cycle, otherwise IDLE.
  - Transfer and an accepted last beat in the same cycle: out_valid stays 1 with the new result, giving full throughput of 1 window per cycle.
- An all-sparse window outputs out_data=0, out_nz_cnt=0.
- Without saturation, arithmetic wraps modulo 2^ACC_W.

Optional Feature:
- Macro: SPARSE_MAC_ACC_SAT_EN.
- Defined:
  - Each addition saturates to [-(2^(ACC_W-1)), 2^(ACC_W-1)-1].
  - Any clamp sets a per-window sticky ovf, reported on out_ovf with the result.
- Undefined:
  - Two's-complement wrap; out_ovf tied to 0; no saturation logic is synthesized.

Decomposition:
- Package sparse_mac_pkg holds:
  - state encoding constants (IDLE=2'd0, ACCUM=2'd1, HOLD=2'd2);
  - PROD_W=6;
  - default ACC_W and CNT_W.
- One sub-module, sparse_mac_sat_add: combinational signed add of acc and sign-extended term.
  - It carries the saturation/overflow logic under the macro.
  - Its outputs are the sum and an overflow flag.

Test Plan:
- Nine beats of +49 (in_neg=0), last on the 9th, out_ready=1 -> one cycle later out_valid=1, out_data=441, out_nz_cnt=9, out_ovf=0.
- Beats +35, -42, (in_zero=1, prod=12), +6 last -> out_data=-1, out_nz_cnt=3; a beat with in_neg=1 and prod=0 -> term 0, not counted.
- Result pending with out_ready low for 5 cycles -> out_data/out_nz_cnt stable, in_ready=0, upstream beats stall; out_ready=1 -> transfer, in_ready=1 the same cycle.
- Back-to-back single-beat windows +7 last, -3 last, +0 last with out_ready=1 -> outputs 7, -3, 0 on consecutive cycles; out_valid never drops.
- ACC_W=8, four beats of +49 -> with SPARSE_MAC_ACC_SAT_EN: out_data=127, out_ovf=1; without it: out_data=-60, out_ovf=0; the next window +5 last -> 5, ovf=0.
- Three beats of +20 accepted, then rst high for one cycle -> out_valid=0, no result emitted; then +7 last -> out_data=7, out_nz_cnt=1.
